// File: rtl/brm_pkg.sv
// Shared types and helpers for the bounded-delay response monitor.
package brm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam int DLY_W = 8;

  function automatic logic [DLY_W-1:0] sat_inc_dly(input logic [DLY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bounded_response_monitor_if.sv
// Stream inputs, match values and verdict outputs of the response monitor.
interface bounded_response_monitor_if #(
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic [W-1:0]     x_in;
  logic [W-1:0]     y_in;
  logic [W-1:0]     trig_val;
  logic [W-1:0]     resp_val;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] overlap_cnt;

  modport master (
    output x_in, y_in, trig_val, resp_val,
    input  busy, pass, fail, pass_cnt, fail_cnt, overlap_cnt
  );

  modport slave (
    input  x_in, y_in, trig_val, resp_val,
    output busy, pass, fail, pass_cnt, fail_cnt, overlap_cnt
  );
endinterface

// File: rtl/brm_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module brm_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bounded_response_monitor.sv
// Run-time checker for trigger |-> ##[MIN_DLY:MAX_DLY] response with registered pass/fail pulses.
// Defining BRM_UNBOUNDED_EN turns the window into ##[MIN_DLY:$]: no timeout, fail never fires.
module bounded_response_monitor
  import brm_pkg::*;
#(
  parameter int W       = 32,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 10,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  bounded_response_monitor_if.slave  mon
);

  localparam logic [DLY_W-1:0] MIN_L = DLY_W'(MIN_DLY);
  localparam logic [DLY_W-1:0] MAX_L = DLY_W'(MAX_DLY);

  logic [W-1:0]     x_w;
  logic [W-1:0]     y_w;
  logic             trig;
  logic             resp;

  state_t           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             ovl_inc;

  assign x_w  = mon.x_in;
  assign y_w  = mon.y_in;
  assign trig = (x_w == mon.trig_val);
  assign resp = (y_w == mon.resp_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dly_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // dly_q holds the offset of the current cycle relative to the trigger cycle.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    ovl_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = ARMED;
          dly_d   = 8'd1;
        end
      end
      ARMED: begin
        ovl_inc = trig;
        if (dly_q < MIN_L) begin
          dly_d = sat_inc_dly(dly_q);
        end else if (resp) begin
          pass_d  = 1'b1;
          state_d = IDLE;
          dly_d   = '0;
`ifdef BRM_UNBOUNDED_EN
        end else begin
          dly_d = sat_inc_dly(dly_q);
        end
`else
        end else if (dly_q >= MAX_L) begin
          fail_d  = 1'b1;
          state_d = IDLE;
          dly_d   = '0;
        end else begin
          dly_d = sat_inc_dly(dly_q);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        dly_d   = '0;
      end
    endcase
  end

  brm_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pass_d),
    .cnt_o (mon.pass_cnt)
  );

  brm_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fail_d),
    .cnt_o (mon.fail_cnt)
  );

  brm_sat_counter #(.CNT_W(CNT_W)) u_overlap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ovl_inc),
    .cnt_o (mon.overlap_cnt)
  );

  assign mon.busy = (state_q == ARMED);
  assign mon.pass = pass_q;
  assign mon.fail = fail_q;

endmodule

// File: tb/tb_bounded_response_monitor.sv
// Directed bench for three monitor instances with different windows, checked against an offset-based model.
module tb_bounded_response_monitor;

  localparam int N = 3;
  localparam int CMAX = 65535;
`ifdef BRM_UNBOUNDED_EN
  localparam bit UNB = 1'b1;
`else
  localparam bit UNB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x = 32'hDEAD_BEEF;
  logic [31:0] y = 32'hDEAD_BEEF;
  logic [31:0] tv [N];
  logic [31:0] rv [N];

  int mins [N] = '{1, 1, 2};
  int maxs [N] = '{10, 1, 3};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bounded_response_monitor_if #(.W(32), .CNT_W(16)) if_a ();
  bounded_response_monitor_if #(.W(32), .CNT_W(16)) if_b ();
  bounded_response_monitor_if #(.W(32), .CNT_W(16)) if_c ();

  assign if_a.x_in = x;  assign if_a.y_in = y;  assign if_a.trig_val = tv[0];  assign if_a.resp_val = rv[0];
  assign if_b.x_in = x;  assign if_b.y_in = y;  assign if_b.trig_val = tv[1];  assign if_b.resp_val = rv[1];
  assign if_c.x_in = x;  assign if_c.y_in = y;  assign if_c.trig_val = tv[2];  assign if_c.resp_val = rv[2];

  bounded_response_monitor #(.W(32), .MIN_DLY(1), .MAX_DLY(10), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .mon(if_a));
  bounded_response_monitor #(.W(32), .MIN_DLY(1), .MAX_DLY(1),  .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .mon(if_b));
  bounded_response_monitor #(.W(32), .MIN_DLY(2), .MAX_DLY(3),  .CNT_W(16)) dut_c (.clk(clk), .rst(rst), .mon(if_c));

  logic        busy_w [N];
  logic        pass_w [N];
  logic        fail_w [N];
  logic [15:0] pc_w   [N];
  logic [15:0] fc_w   [N];
  logic [15:0] oc_w   [N];

  assign busy_w[0] = if_a.busy;  assign pass_w[0] = if_a.pass;  assign fail_w[0] = if_a.fail;
  assign pc_w[0] = if_a.pass_cnt;  assign fc_w[0] = if_a.fail_cnt;  assign oc_w[0] = if_a.overlap_cnt;
  assign busy_w[1] = if_b.busy;  assign pass_w[1] = if_b.pass;  assign fail_w[1] = if_b.fail;
  assign pc_w[1] = if_b.pass_cnt;  assign fc_w[1] = if_b.fail_cnt;  assign oc_w[1] = if_b.overlap_cnt;
  assign busy_w[2] = if_c.busy;  assign pass_w[2] = if_c.pass;  assign fail_w[2] = if_c.fail;
  assign pc_w[2] = if_c.pass_cnt;  assign fc_w[2] = if_c.fail_cnt;  assign oc_w[2] = if_c.overlap_cnt;

  task automatic chk(input string nm, input int inst, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst%0d at %0t: got=%0d want=%0d", nm, inst, $time, act, exp);
    end
  endtask

  // Model: an obligation is the absolute cycle number of its trigger; offset = now - trigger cycle.
  int cyc = 0;
  bit m_armed [N];
  int m_trig_at [N];
  bit m_pass [N];
  bit m_fail [N];
  int m_pc [N];
  int m_fc [N];
  int m_oc [N];

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_armed[i] = 1'b0; m_pass[i] = 1'b0; m_fail[i] = 1'b0;
        m_pc[i] = 0; m_fc[i] = 0; m_oc[i] = 0;
      end else begin
        m_pass[i] = 1'b0;
        m_fail[i] = 1'b0;
        if (!m_armed[i]) begin
          if (x == tv[i]) begin
            m_armed[i]   = 1'b1;
            m_trig_at[i] = cyc;
          end
        end else begin
          int k;
          k = cyc - m_trig_at[i];
          if (x == tv[i]) m_oc[i] = sat(m_oc[i]);
          if (k >= mins[i] && y == rv[i]) begin
            m_pass[i] = 1'b1; m_pc[i] = sat(m_pc[i]); m_armed[i] = 1'b0;
          end else if (!UNB && k >= maxs[i]) begin
            m_fail[i] = 1'b1; m_fc[i] = sat(m_fc[i]); m_armed[i] = 1'b0;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk("busy",     i, busy_w[i], rst ? 0 : m_armed[i]);
      chk("pass",     i, pass_w[i], rst ? 0 : m_pass[i]);
      chk("fail",     i, fail_w[i], rst ? 0 : m_fail[i]);
      chk("pass_cnt", i, pc_w[i],   rst ? 0 : m_pc[i]);
      chk("fail_cnt", i, fc_w[i],   rst ? 0 : m_fc[i]);
      chk("ovl_cnt",  i, oc_w[i],   rst ? 0 : m_oc[i]);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    x = 32'hDEAD_BEEF;
    y = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tv = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    rv = '{32'hFFFF_0001, 32'hFFFF_0001, 32'hFFFF_0001};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 0, if_a.busy, 0);
    chk("rst_pcnt", 0, if_a.pass_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Counter stimulus: A passes at offset 9, B at offset 1, C ignores an early match then fails.
    tv = '{32'd1, 32'd0, 32'd3};
    rv = '{32'd20, 32'd2, 32'd8};
    for (int c = 0; c < 14; c++) begin
      x = c; y = 2 * c;
      @(negedge clk);
      if (c == 2)  chk("b_pass_off1", 1, pass_w[1], 1);
      if (c == 7)  chk("c_fail_min2", 2, fail_w[2], 1);
      if (c == 10) chk("a_busy_off9", 0, busy_w[0], 1);
      if (c == 11) begin
        chk("a_pass_c11", 0, pass_w[0], 1);
        chk("a_busy_c11", 0, busy_w[0], 0);
        chk("a_pcnt_c11", 0, pc_w[0], 1);
      end
      @(posedge clk); #1;
    end
    chk("a_fcnt_end", 0, fc_w[0], 0);
    chk("c_pcnt_end", 2, pc_w[2], 0);

    // Same stimulus, responses that land outside the windows.
    do_reset();
    rv = '{32'd30, 32'd4, 32'd8};
    for (int c = 0; c < 14; c++) begin
      x = c; y = 2 * c;
      @(negedge clk);
      if (c == 2) begin
        chk("b_fail_off1", 1, fail_w[1], 1);
        chk("b_fcnt_c2",   1, fc_w[1], 1);
      end
      if (c == 11) begin
        chk("a_busy_c11", 0, busy_w[0], 1);
        chk("a_fail_c11", 0, fail_w[0], 0);
      end
      if (c == 12) begin
        chk("a_fail_c12", 0, fail_w[0], 1);
        chk("a_busy_c12", 0, busy_w[0], 0);
        chk("a_fcnt_c12", 0, fc_w[0], 1);
      end
      @(posedge clk); #1;
    end

    // Trigger held for 5 cycles on C: overlaps during the window, re-arm right after the fail.
    do_reset();
    tv = '{32'd1234, 32'd1234, 32'd5};
    rv = '{32'd777, 32'd777, 32'd777};
    for (int c = 0; c < 10; c++) begin
      x = (c < 5) ? 32'd5 : 32'(c + 1); y = 32'd0;
      @(negedge clk);
      if (c == 4) begin
        chk("c_fail_c4", 2, fail_w[2], 1);
        chk("c_busy_c4", 2, busy_w[2], 0);
        chk("c_fcnt_c4", 2, fc_w[2], 1);
        chk("c_ocnt_c4", 2, oc_w[2], 3);
      end
      if (c == 5) begin
        chk("c_rearm_c5", 2, busy_w[2], 1);
        chk("c_ocnt_c5",  2, oc_w[2], 3);
      end
      if (c == 8) chk("c_fcnt_c8", 2, fc_w[2], 2);
      @(posedge clk); #1;
    end

    // Reset at offset 5 of A's open window; B has already counted a fail.
    do_reset();
    tv = '{32'd1, 32'd2, 32'd1234};
    rv = '{32'd999, 32'd999, 32'd999};
    for (int c = 0; c < 20; c++) begin
      x = c; y = 2 * c;
      if (c == 6) rst = 1'b1;
      if (c == 7) rst = 1'b0;
      @(negedge clk);
      if (c == 5) begin
        chk("a_busy_pre_rst", 0, busy_w[0], 1);
        chk("b_fcnt_pre_rst", 1, fc_w[1], 1);
      end
      if (c == 6) begin
        chk("a_busy_rst", 0, busy_w[0], 0);
        chk("b_fcnt_rst", 1, fc_w[1], 0);
      end
      @(posedge clk); #1;
    end
    chk("a_fcnt_post_rst", 0, fc_w[0], 0);

`ifdef BRM_UNBOUNDED_EN
    do_reset();
    tv = '{32'd0, 32'd0, 32'd1234};
    rv = '{32'd18, 32'd18, 32'd777};
    for (int c = 0; c < 14; c++) begin
      x = c; y = 2 * c;
      @(negedge clk);
      if (c == 9)  chk("u_a_busy_c9",  0, busy_w[0], 1);
      if (c == 10) chk("u_a_pass_c10", 0, pass_w[0], 1);
      @(posedge clk); #1;
    end
    do_reset();
    rv = '{32'd1, 32'd1, 32'd777};
    for (int c = 0; c < 300; c++) begin
      x = c; y = 2 * c;
      @(posedge clk); #1;
    end
    chk("u_a_busy_300", 0, busy_w[0], 1);
    chk("u_a_fcnt_300", 0, fc_w[0], 0);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
